sysbus_mem_responder: RTL and testbench

- Memory-side responder for the system bus: the target that page-table walkers, caches and other initiators talk to through the arbiter.
- Accepts one request at a time: a line read or a line write, both 64-byte lines (8 beats x 64 bits).
- Backed by an internal word array.
- Reads return 8 response beats, each beat handshaken by respack. Writes absorb 8 data beats from the initiator.

---
 rtl/sysbus_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//   Memory-side target on the system bus. Serves one request at a time:
//   64-byte line reads (8 response beats, each handed over on respack) and
//   64-byte line writes (8 data beats absorbed after the header).
//   Backed by an internal array of 64-bit words. Array contents survive reset.
//
// Build option:
//   MEMRESP_CRITICAL_WORD_FIRST_EN - when defined, read bursts start at the
//   word selected by req[5:3] of the header and wrap within the line.
//   When undefined, read bursts always return words 0..7 in order.
//
// Ports:
//   clk               clock, all state on rising edge
//   reset             asynchronous active-low reset
//   main_bus_reqcyc   request header / write data beat valid
//   main_bus_req      header address or write data
//   main_bus_reqtag   request tag ({direction, device, 8'h00})
//   main_bus_reqack   header or data beat accepted this cycle
//   main_bus_respcyc  response beat valid
//   main_bus_resp     response data
//   main_bus_resptag  tag of the read being answered
//   main_bus_respack  initiator consumes the current response beat

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      main_bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  output logic                      main_bus_reqack,
  output logic                      main_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  input  logic                      main_bus_respack
);

  // State | meaning
  // IDLE  | waiting for a READ or WRITE header addressed to memory
  // WDATA | absorbing the 8 write data beats of the accepted line
  // RLAT  | read latency countdown before the first response beat
  // RESP  | presenting read beats, advancing on respack

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LINE_W = AW - 3;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [BUS_TAG_WIDTH-1:0] TAG_READ =
    BUS_TAG_WIDTH'((`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8));
  localparam logic [BUS_TAG_WIDTH-1:0] TAG_WRITE =
    BUS_TAG_WIDTH'((`SYSBUS_WRITE << 12) | (`SYSBUS_MEMORY << 8));

  typedef enum logic [1:0] {IDLE, WDATA, RLAT, RESP} state_t;

  state_t                    state, state_next;
  logic [2:0]                beat, beat_next;
  logic [LAT_W-1:0]          lat_cnt, lat_cnt_next;
  logic [LINE_W-1:0]         line, line_next;
  logic [BUS_TAG_WIDTH-1:0]  tag, tag_next;
  logic                      is_read, is_write;
  logic                      wr_en;
  logic [AW-1:0]             wr_idx, rd_idx;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign is_read  = (main_bus_reqtag == TAG_READ);
  assign is_write = (main_bus_reqtag == TAG_WRITE);

  // Only the low line bits are kept, so upper address bits alias silently.
  assign wr_idx = {line, beat};

`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
  logic [2:0] start, start_next;
  assign rd_idx = {line, 3'(beat + start)};
`else
  assign rd_idx = {line, beat};
`endif

  always_comb begin
    state_next       = state;
    beat_next        = beat;
    lat_cnt_next     = lat_cnt;
    line_next        = line;
    tag_next         = tag;
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
    start_next       = start;
`endif
    wr_en            = 1'b0;
    main_bus_reqack  = 1'b0;
    main_bus_respcyc = 1'b0;
    main_bus_resp    = '0;
    main_bus_resptag = '0;
    case (state)
      IDLE: begin
        if (main_bus_reqcyc && (is_read || is_write)) begin
          main_bus_reqack = 1'b1;
          line_next       = main_bus_req[6 +: LINE_W];
          beat_next       = 3'd0;
          if (is_read) begin
            tag_next     = main_bus_reqtag;
            lat_cnt_next = LAT_W'(READ_LATENCY - 1);
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
            start_next   = main_bus_req[5:3];
`endif
            state_next   = RLAT;
          end else begin
            state_next = WDATA;
          end
        end
      end
      WDATA: begin
        main_bus_reqack = main_bus_reqcyc;
        if (main_bus_reqcyc) begin
          wr_en     = 1'b1;
          beat_next = beat + 3'd1;
          if (beat == 3'd7) state_next = IDLE;
        end
      end
      RLAT: begin
        // Loaded with READ_LATENCY-1, so RESP is entered READ_LATENCY edges after accept.
        if (lat_cnt == '0) begin
          beat_next  = 3'd0;
          state_next = RESP;
        end else begin
          lat_cnt_next = lat_cnt - 1'b1;
        end
      end
      RESP: begin
        main_bus_respcyc = 1'b1;
        main_bus_resp    = mem[rd_idx];
        main_bus_resptag = tag;
        if (main_bus_respack) begin
          beat_next = beat + 3'd1;
          if (beat == 3'd7) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beat    <= '0;
      lat_cnt <= '0;
      line    <= '0;
      tag     <= '0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      lat_cnt <= lat_cnt_next;
      line    <= line_next;
      tag     <= tag_next;
    end
  end

`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) start <= '0;
    else        start <= start_next;
  end
`endif

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= main_bus_req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Testbench for sysbus_mem_responder: tag-classification vector table,
// directed multi-cycle sequences and randomized line traffic checked
// against a word-addressed memory model.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module tb_sysbus_mem_responder;

  localparam int MEM_WORDS    = 4096;
  localparam int READ_LATENCY = 4;
  localparam logic [12:0] TAG_RD = 13'((`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8));
  localparam logic [12:0] TAG_WR = 13'((`SYSBUS_WRITE << 12) | (`SYSBUS_MEMORY << 8));

  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] model [int];
  logic [63:0] written [$];

  typedef struct packed {
    logic        cyc;
    logic [12:0] tag;
    logic        exp_ack;
  } vec_t;
  vec_t vecs [8];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .MEM_WORDS     (MEM_WORDS),
    .READ_LATENCY  (READ_LATENCY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .main_bus_reqcyc (reqcyc),
    .main_bus_req    (req),
    .main_bus_reqtag (reqtag),
    .main_bus_reqack (reqack),
    .main_bus_respcyc(respcyc),
    .main_bus_resp   (resp),
    .main_bus_resptag(resptag),
    .main_bus_respack(respack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running (required: finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Word index as the bus defines it: line*8 + beat, modulo array depth.
  function automatic int widx(input logic [63:0] addr, input int b);
    logic [63:0] w;
    w = ((addr >> 6) << 3) + 64'(b);
    return int'(w % 64'(MEM_WORDS));
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] addr, input int b);
    int first;
    int i;
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
    first = int'(addr[5:3]);
`else
    first = 0;
`endif
    i = widx(addr, (first + b) % 8);
    if (model.exists(i)) return model[i];
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic wait_ack(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reqack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: reqack not seen within 40 cycles, required 1", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] d [8], input bit stalls);
    bit ok;
    int b;
    reqcyc = 1'b1; req = addr; reqtag = TAG_WR;
    wait_ack("wr_hdr_ack", ok);
    if (!ok) begin reqcyc = 1'b0; return; end
    reqtag = '0;  // a header-class tag on a data beat would mask an early return to IDLE
    b = 0;
    while (b < 8) begin
      if (stalls && $urandom_range(0, 3) == 0) begin
        reqcyc = 1'b0; req = {$urandom, $urandom};
        @(negedge clk);
        chk("wr_stall_ack", 64'(reqack), 64'd0);
        @(posedge clk); #1;
      end else begin
        reqcyc = 1'b1; req = d[b];
        @(negedge clk);
        chk("wr_data_ack", 64'(reqack), 64'd1);
        chk("wr_no_respcyc", 64'(respcyc), 64'd0);
        @(posedge clk); #1;
        model[widx(addr, b)] = d[b];
        b++;
      end
    end
    reqcyc = 1'b0; req = '0; reqtag = '0;
  endtask

  task automatic do_read(input logic [63:0] addr, input int stall_beat, input int stall_len,
                         input bit rnd_ack, input bit hold_next, input logic [63:0] next_addr,
                         input int rst_beat);
    bit ok, got, ack;
    int lat, beat, waited, stalled;
    reqcyc = 1'b1; req = addr; reqtag = TAG_RD;
    wait_ack("rd_hdr_ack", ok);
    if (!ok) begin reqcyc = 1'b0; return; end
    if (hold_next) begin
      req = next_addr;
    end else begin
      reqcyc = 1'b0; req = '0; reqtag = '0;
    end
    lat = 0; got = 1'b0;
    while (lat <= READ_LATENCY + 4) begin
      @(negedge clk);
      if (respcyc === 1'b1) begin got = 1'b1; break; end
      chk("rlat_reqack", 64'(reqack), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("rd_latency", 64'(lat), 64'(READ_LATENCY));
    if (!got) begin reqcyc = 1'b0; return; end
    beat = 0; waited = 0; stalled = 0;
    while (beat < 8 && waited < 200) begin
      chk("rd_respcyc", 64'(respcyc), 64'd1);
      chk($sformatf("rd_beat%0d", beat), resp, exp_word(addr, beat));
      chk("rd_tag", 64'(resptag), 64'(TAG_RD));
      chk("rd_busy_reqack", 64'(reqack), 64'd0);
      if (beat == rst_beat) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_async_respcyc", 64'(respcyc), 64'd0);
        chk("rst_async_resp", resp, 64'd0);
        chk("rst_async_resptag", 64'(resptag), 64'd0);
        respack = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_respcyc", 64'(respcyc), 64'd0);
        return;
      end
      if (rnd_ack) ack = 1'($urandom_range(0, 1));
      else ack = !(beat == stall_beat && stalled < stall_len);
      if (!ack) stalled++;
      respack = ack;
      @(posedge clk); #1;
      if (ack) beat++;
      waited++;
      @(negedge clk);
    end
    respack = 1'b0;
    chk("rd_beats_done", 64'(beat), 64'd8);
    chk("rd_end_respcyc", 64'(respcyc), 64'd0);
    chk("rd_end_resp", resp, 64'd0);
    chk("rd_end_resptag", 64'(resptag), 64'd0);
    if (hold_next) chk("held_hdr_ack_after_last", 64'(reqack), 64'd1);
    reqcyc = 1'b0; req = '0; reqtag = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] wd [8];
    logic [63:0] base, addr;
    vecs[0] = '{cyc: 1'b1, tag: TAG_RD,              exp_ack: 1'b1};
    vecs[1] = '{cyc: 1'b1, tag: TAG_WR,              exp_ack: 1'b1};
    vecs[2] = '{cyc: 1'b0, tag: TAG_RD,              exp_ack: 1'b0};
    vecs[3] = '{cyc: 1'b0, tag: TAG_WR,              exp_ack: 1'b0};
    vecs[4] = '{cyc: 1'b1, tag: TAG_RD | 13'h0F00,   exp_ack: 1'b0};
    vecs[5] = '{cyc: 1'b1, tag: TAG_RD | 13'h0001,   exp_ack: 1'b0};
    vecs[6] = '{cyc: 1'b1, tag: 13'h1000,            exp_ack: 1'b0};
    vecs[7] = '{cyc: 1'b1, tag: TAG_WR | 13'h0080,   exp_ack: 1'b0};

    reset = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_reqack", 64'(reqack), 64'd0);
    chk("reset_respcyc", 64'(respcyc), 64'd0);
    chk("reset_resp", resp, 64'd0);
    chk("reset_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Tag classification in IDLE; reqcyc drops before the edge so nothing is accepted.
    for (int i = 0; i < 8; i++) begin
      reqcyc = vecs[i].cyc; reqtag = vecs[i].tag; req = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("tag_vec%0d_reqack", i), 64'(reqack), 64'(vecs[i].exp_ack));
      chk($sformatf("tag_vec%0d_respcyc", i), 64'(respcyc), 64'd0);
      reqcyc = 1'b0;
      @(posedge clk); #1;
    end

    // Line 0x1000 with 0x11..0x88, then plain read.
    for (int b = 0; b < 8; b++) wd[b] = 64'((b + 1) * 8'h11);
    do_write(64'h1000, wd, 1'b0);
    written.push_back(64'h1000);
    do_read(64'h1000, -1, 0, 1'b0, 1'b0, 64'h0, -1);

    // Respack withheld five cycles on beat 2.
    do_read(64'h1000, 2, 5, 1'b0, 1'b0, 64'h0, -1);

    // Second read held on the bus during the first burst.
    for (int b = 0; b < 8; b++) wd[b] = 64'hA5A5_0000_0000_0000 | 64'(b * 3 + 7);
    do_write(64'h2000, wd, 1'b1);
    written.push_back(64'h2000);
    do_read(64'h1000, -1, 0, 1'b0, 1'b1, 64'h2000, -1);
    do_read(64'h2000, -1, 0, 1'b0, 1'b0, 64'h0, -1);

    // Foreign device tag held for 20 cycles.
    reqcyc = 1'b1; req = 64'h1000; reqtag = 13'((`SYSBUS_READ << 12) | (4'hF << 8));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bad_dev_reqack", 64'(reqack), 64'd0);
      chk("bad_dev_respcyc", 64'(respcyc), 64'd0);
      @(posedge clk); #1;
    end
    reqcyc = 1'b0; req = '0; reqtag = '0;

    // Reset during beat 4, then a fresh read still sees the array contents.
    do_read(64'h1000, -1, 0, 1'b0, 1'b0, 64'h0, 4);
    do_read(64'h1000, -1, 0, 1'b0, 1'b0, 64'h0, -1);

    // Offset inside the line (critical word order when that build option is on).
    do_read(64'h1028, -1, 0, 1'b0, 1'b0, 64'h0, -1);

    // Upper address bits alias onto the same array line.
    do_read(64'h1000 + 64'(MEM_WORDS * 8) * 3 + 64'h18, -1, 0, 1'b1, 1'b0, 64'h0, -1);

    // Randomized writes and reads with stalls, random acks and aliased addresses.
    for (int it = 0; it < 40; it++) begin
      if (written.size() < 2 || $urandom_range(0, 2) == 0) begin
        base = 64'($urandom_range(0, MEM_WORDS / 8 - 1)) << 6;
        addr = base + 64'($urandom_range(0, 7)) * 64'(MEM_WORDS * 8) + 64'($urandom_range(0, 63));
        for (int b = 0; b < 8; b++) wd[b] = {$urandom, $urandom};
        do_write(addr, wd, 1'b1);
        written.push_back(base);
      end else begin
        base = written[$urandom_range(0, written.size() - 1)];
        addr = base + 64'($urandom_range(0, 7)) * 64'(MEM_WORDS * 8) + 64'($urandom_range(0, 63));
        do_read(addr, -1, 0, 1'b1, 1'b0, 64'h0, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
